// File: rtl/zynet_cfg_loader_if.sv
// zynet_cfg_loader_if: AXI4-Lite write-channel bundle between the config loader and zyNet's s_axi port
interface zynet_cfg_loader_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  modport master(output awaddr, awvalid, wdata, wstrb, wvalid, bready,
                 input awready, wready, bresp, bvalid);
  modport slave(input awaddr, awvalid, wdata, wstrb, wvalid, bready,
                output awready, wready, bresp, bvalid);
endinterface

// File: rtl/zynet_cfg_loader.sv
// zynet_cfg_loader: AXI4-Lite master replaying soft-reset clear, weights and biases from config memory into zyNet
module zynet_cfg_loader #(
  parameter int NUM_LAYERS = 4,
  parameter int DATA_W = 16,
  parameter int MEM_AW = 16,
  parameter logic [8*NUM_LAYERS-1:0]  NEURONS_PKD = {8'd10, 8'd10, 8'd30, 8'd30},
  parameter logic [16*NUM_LAYERS-1:0] WEIGHTS_PKD = {16'd10, 16'd30, 16'd30, 16'd784}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cfg_rd_en,
  output logic [MEM_AW-1:0] cfg_rd_addr,
  input  logic [DATA_W-1:0] cfg_rd_data,
  zynet_cfg_loader_if.master m_axi
);
  typedef enum logic [2:0] {IDLE, SEL, FETCH, RDWAIT, WR, RESP, DONE} state_t;
  typedef enum logic [1:0] {K_SRST, K_LAYER, K_NEURON, K_DATA} kind_t;
  state_t state_q, state_d;
  kind_t kind_q, kind_d;
  logic pass_q, pass_d;
  logic [7:0] layer_q, layer_d, neuron_q, neuron_d, n_k;
  logic [15:0] weight_q, weight_d, w_k;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, rd_en_q, rd_en_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [MEM_AW-1:0] rd_addr_q, rd_addr_d;
  logic last_w, last_n, last_l;
  assign n_k = NEURONS_PKD[8*(int'(layer_q)-1) +: 8];
  assign w_k = WEIGHTS_PKD[16*(int'(layer_q)-1) +: 16];
  assign last_w = weight_q == w_k - 16'd1;
  assign last_n = neuron_q == n_k - 8'd1;
  assign last_l = int'(layer_q) == NUM_LAYERS;
  // kind_q names the write issued next; the data kind reads weight or bias depending on pass_q
  always_comb begin
    state_d = state_q;
    kind_d = kind_q;
    pass_d = pass_q;
    layer_d = layer_q;
    neuron_d = neuron_q;
    weight_d = weight_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = err_q;
    rd_en_d = rd_en_q;
    rd_addr_d = rd_addr_q;
    awvalid_d = awvalid_q;
    wvalid_d = wvalid_q;
    bready_d = bready_q;
    awaddr_d = awaddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SEL;
        kind_d = K_SRST;
        pass_d = 1'b0;
        layer_d = 8'd1;
        neuron_d = 8'd0;
        weight_d = 16'd0;
        rd_addr_d = '0;
        busy_d = 1'b1;
        err_d = 1'b0;
      end
      SEL: begin
        awaddr_d = kind_q == K_SRST ? 32'd28 : kind_q == K_LAYER ? 32'd12 :
                   kind_q == K_NEURON ? 32'd16 : pass_q ? 32'd4 : 32'd0;
        wdata_d = kind_q == K_LAYER ? {24'd0, layer_q} : kind_q == K_NEURON ? {24'd0, neuron_q} : 32'd0;
        rd_en_d = kind_q == K_DATA;
        awvalid_d = kind_q != K_DATA;
        wvalid_d = kind_q != K_DATA;
        state_d = kind_q == K_DATA ? FETCH : WR;
      end
      FETCH: begin
        rd_en_d = 1'b0;
        state_d = RDWAIT;
      end
      RDWAIT: begin
        wdata_d = 32'(cfg_rd_data);
        rd_addr_d = rd_addr_q + MEM_AW'(1);
        awvalid_d = 1'b1;
        wvalid_d = 1'b1;
        state_d = WR;
      end
      WR: begin
        awvalid_d = awvalid_q && !m_axi.awready;
        wvalid_d = wvalid_q && !m_axi.wready;
        bready_d = !awvalid_d && !wvalid_d;
        state_d = bready_d ? RESP : WR;
      end
      RESP: if (m_axi.bvalid) begin
        bready_d = 1'b0;
        err_d = err_q | (m_axi.bresp != 2'b00);
        state_d = SEL;
        case (kind_q)
          K_SRST: kind_d = K_LAYER;
          K_LAYER: begin
            kind_d = K_NEURON;
            neuron_d = 8'd0;
          end
          K_NEURON: begin
            kind_d = K_DATA;
            weight_d = 16'd0;
          end
          default: begin
            weight_d = (pass_q || last_w) ? 16'd0 : weight_q + 16'd1;
            if (!pass_q && !last_w) kind_d = K_DATA;
            else if (!last_n) begin
              neuron_d = neuron_q + 8'd1;
              kind_d = K_NEURON;
            end else if (!last_l) begin
              neuron_d = 8'd0;
              layer_d = layer_q + 8'd1;
              kind_d = K_LAYER;
            end else if (!pass_q) begin
              neuron_d = 8'd0;
              layer_d = 8'd1;
              pass_d = 1'b1;
              kind_d = K_LAYER;
            end else begin
              state_d = DONE;
              done_d = 1'b1;
              busy_d = 1'b0;
            end
          end
        endcase
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      kind_q <= K_SRST;
      pass_q <= 1'b0;
      layer_q <= 8'd1;
      neuron_q <= 8'd0;
      weight_q <= 16'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      rd_en_q <= 1'b0;
      rd_addr_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      bready_q <= 1'b0;
      awaddr_q <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      kind_q <= kind_d;
      pass_q <= pass_d;
      layer_q <= layer_d;
      neuron_q <= neuron_d;
      weight_q <= weight_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      rd_en_q <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
      bready_q <= bready_d;
      awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign cfg_rd_en = rd_en_q;
  assign cfg_rd_addr = rd_addr_q;
  assign m_axi.awaddr = awaddr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata = wdata_q;
  assign m_axi.wstrb = 4'hF;
  assign m_axi.wvalid = wvalid_q;
  assign m_axi.bready = bready_q;
endmodule

// File: tb/tb_zynet_cfg_loader.sv
// tb_zynet_cfg_loader: scenario table plus random runs against a write-sequence model built from the network shape
module tb_zynet_cfg_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, clr = 1'b0;
  logic busy, done, err, cfg_rd_en;
  logic [15:0] cfg_rd_addr, cfg_rd_data;
  zynet_cfg_loader_if axi();
  zynet_cfg_loader #(
    .NUM_LAYERS(2), .DATA_W(16), .MEM_AW(16),
    .NEURONS_PKD({8'd3, 8'd2}), .WEIGHTS_PKD({16'd2, 16'd3})
  ) dut (
    .clock(clk), .reset(rst), .start(start), .busy(busy), .done(done), .err(err),
    .cfg_rd_en(cfg_rd_en), .cfg_rd_addr(cfg_rd_addr), .cfg_rd_data(cfg_rd_data), .m_axi(axi)
  );
  always #5 clk = ~clk;

  typedef struct {
    int aw_d;
    int w_d;
    int err_i;
    logic exp_err;
    int exp_cyc;
    logic extra;
  } vec_t;

  int checks = 0, errors = 0;
  logic [15:0] mem [32];
  int aw_delay = 0, w_delay = 0, err_idx = -1;
  int aw_wait, w_wait, wr_count, done_cnt, stab_err, dup_err, aw_run, w_run, max_aw, max_w;
  logic aw_got, w_got, bvalid, pend_aw, pend_w;
  logic [1:0] bresp;
  logic [31:0] got_addr, got_data, prev_a, prev_d;
  logic [31:0] log_a[$], log_d[$], exp_a[$], exp_d[$];
  int rd_log[$];
  logic aw_hs, w_hs, wr_fin;

  // behavioural AXI-Lite slave with programmable ready delays and one selectable error response
  assign axi.awready = aw_wait >= aw_delay;
  assign axi.wready = w_wait >= w_delay;
  assign axi.bvalid = bvalid;
  assign axi.bresp = bresp;
  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs = axi.wvalid && axi.wready;
  assign wr_fin = (aw_got || aw_hs) && (w_got || w_hs) && !rst && !clr;

  always @(posedge clk) begin
    cfg_rd_data <= cfg_rd_en ? mem[cfg_rd_addr[4:0]] : 16'hDEAD;
    pend_aw <= axi.awvalid && !axi.awready;
    pend_w <= axi.wvalid && !axi.wready;
    prev_a <= axi.awaddr;
    prev_d <= axi.wdata;
    aw_run <= axi.awvalid ? aw_run + 1 : 0;
    w_run <= axi.wvalid ? w_run + 1 : 0;
    if (clr) begin
      wr_count <= 0; done_cnt <= 0; stab_err <= 0; dup_err <= 0; max_aw <= 0; max_w <= 0;
      log_a.delete(); log_d.delete(); rd_log.delete();
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (cfg_rd_en) rd_log.push_back(int'(cfg_rd_addr));
      if ((pend_aw && axi.awvalid && axi.awaddr != prev_a) || (pend_w && axi.wvalid && axi.wdata != prev_d))
        stab_err <= stab_err + 1;
      if ((axi.awvalid && aw_got) || (axi.wvalid && w_got)) dup_err <= dup_err + 1;
      if (axi.awvalid && aw_run + 1 > max_aw) max_aw <= aw_run + 1;
      if (axi.wvalid && w_run + 1 > max_w) max_w <= w_run + 1;
      if (wr_fin) begin
        log_a.push_back(aw_got ? got_addr : axi.awaddr);
        log_d.push_back(w_got ? got_data : axi.wdata);
        wr_count <= wr_count + 1;
      end
    end
    if (rst || clr) begin
      aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
    end else begin
      if (axi.awvalid && !aw_got) begin
        aw_wait <= axi.awready ? 0 : aw_wait + 1;
        if (axi.awready) begin aw_got <= 1'b1; got_addr <= axi.awaddr; end
      end
      if (axi.wvalid && !w_got) begin
        w_wait <= axi.wready ? 0 : w_wait + 1;
        if (axi.wready) begin w_got <= 1'b1; got_data <= axi.wdata; end
      end
      if (bvalid && axi.bready) bvalid <= 1'b0;
      if (wr_fin) begin
        aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b1;
        bresp <= (wr_count == err_idx) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // expected write stream derived directly from the network shape and memory layout
  function automatic void build_exp();
    int m = 0;
    int nn[2] = '{2, 3};
    int ww[2] = '{3, 2};
    exp_a.delete(); exp_d.delete();
    exp_a.push_back(32'd28); exp_d.push_back(32'd0);
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 2; k++) begin
        exp_a.push_back(32'd12); exp_d.push_back(32'(k + 1));
        for (int j = 0; j < nn[k]; j++) begin
          exp_a.push_back(32'd16); exp_d.push_back(32'(j));
          for (int w = 0; w < (p == 1 ? 1 : ww[k]); w++) begin
            exp_a.push_back(p == 1 ? 32'd4 : 32'd0);
            exp_d.push_back({16'd0, mem[m]});
            m++;
          end
        end
      end
  endfunction

  task automatic kick(input int awd, input int wd, input int ei);
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    build_exp();
    aw_delay = awd; w_delay = wd; err_idx = ei;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("err_cleared_on_start", {31'd0, err}, 32'd0);
  endtask

  task automatic run_case(input string tag, input vec_t v);
    int cyc = 0, bad = 0;
    logic got = 1'b0;
    kick(v.aw_d, v.w_d, v.err_i);
    while (!got && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = v.extra && busy && (cyc == 25 || cyc == 90);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    if (v.exp_cyc != 0) chk({tag, "_cycles"}, 32'(cyc + 1), 32'(v.exp_cyc));
    repeat (4) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
    chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_write_count"}, 32'(log_a.size()), 32'd32);
    chk({tag, "_read_count"}, 32'(rd_log.size()), 32'd17);
    for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] != i) bad++;
    chk({tag, "_read_addr_seq"}, 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < exp_a.size() && i < log_a.size(); i++)
      if (log_a[i] !== exp_a[i] || log_d[i] !== exp_d[i]) begin
        if (bad == 0) $display("FAIL %s_write_log idx=%0d actual=%0h<-%0h expected=%0h<-%0h",
                               tag, i, log_a[i], log_d[i], exp_a[i], exp_d[i]);
        bad++;
      end
    checks++;
    if (bad != 0) errors++;
    chk({tag, "_stable_and_unique"}, 32'(stab_err + dup_err), 32'd0);
    chk({tag, "_awvalid_hold"}, 32'(max_aw), 32'(v.aw_d + 1));
    chk({tag, "_wvalid_hold"}, 32'(max_w), 32'(v.w_d + 1));
  endtask

  vec_t tbl[5];
  vec_t rv;
  int wait_cyc;

  initial begin
    tbl[0] = '{0, 0, -1, 1'b0, 131, 1'b0};
    tbl[1] = '{3, 0, -1, 1'b0, 0, 1'b0};
    tbl[2] = '{0, 0, 4, 1'b1, 0, 1'b0};
    tbl[3] = '{0, 0, -1, 1'b0, 131, 1'b0};
    tbl[4] = '{1, 2, -1, 1'b0, 0, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rd_en", {31'd0, cfg_rd_en}, 32'd0);
    chk("rst_rd_addr", {16'd0, cfg_rd_addr}, 32'd0);
    chk("rst_valids", {29'd0, axi.awvalid, axi.wvalid, axi.bready}, 32'd0);
    chk("rst_awaddr", axi.awaddr, 32'd0);
    chk("rst_wdata", axi.wdata, 32'd0);
    chk("wstrb", {28'd0, axi.wstrb}, 32'hF);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) run_case($sformatf("vec%0d", i), tbl[i]);
    for (int i = 0; i < 4; i++) begin
      rv.aw_d = int'($urandom_range(0, 3));
      rv.w_d = int'($urandom_range(0, 3));
      rv.err_i = int'($urandom_range(0, 40));
      rv.exp_err = rv.err_i < 32;
      rv.exp_cyc = 0;
      rv.extra = 1'b0;
      run_case($sformatf("rnd%0d", i), rv);
    end
    kick(0, 0, -1);
    wait_cyc = 0;
    while (!(wr_count == 9 && axi.awvalid) && wait_cyc < 500) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("reach_10th_write", {31'd0, wr_count == 9 && axi.awvalid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valids", {29'd0, axi.awvalid, axi.wvalid, axi.bready}, 32'd0);
    chk("abort_busy", {30'd0, busy, cfg_rd_en}, 32'd0);
    rst = 1'b0;
    rv = '{0, 0, -1, 1'b0, 131, 1'b0};
    run_case("replay", rv);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
